// File: rtl/pll_reset_sequencer_pkg.sv
// ============================================================================
// Module : pll_seq_pkg
// Shared state encoding, default timing and counter sizing for the PLL
// reset sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pll_seq_pkg;

  localparam int STATE_W = 2;
  localparam int RETRY_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int DEF_RST_CYCLES    = 32;
  localparam int DEF_LOCK_TIMEOUT  = 500000;
  localparam int DEF_STABLE_CYCLES = 65536;
  localparam int DEF_SOFT_HOLD     = 16;

  // Width of the one counter shared by all states; it only ever reaches max-1.
  function automatic int CNT_W(input int rst_cycles, input int lock_timeout,
                               input int stable_cycles);
    int m;
    m = rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_reset_sequencer_if.sv
// ============================================================================
// Module : pll_reset_sequencer_if
// PLL status/control and core reset signals seen by the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pll_reset_sequencer_if;
  import pll_seq_pkg::*;

  logic               pll_locked;
  logic               soft_rst_req;
  logic               pll_rst;
  logic               core_reset;
  logic               ready;
  state_e             state;
  logic [RETRY_W-1:0] retry_cnt;
  logic               lock_lost;

  modport master (
    output pll_locked, soft_rst_req,
    input  pll_rst, core_reset, ready, state, retry_cnt, lock_lost
  );

  modport slave (
    input  pll_locked, soft_rst_req,
    output pll_rst, core_reset, ready, state, retry_cnt, lock_lost
  );

endinterface

`default_nettype wire

// File: rtl/pll_reset_sequencer_sync2.sv
// ============================================================================
// Module : sync2
// Two-flop single-bit synchronizer with synchronous reset to 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync2 (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d_i,
  output logic      q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module : pll_reset_sequencer
// Pulses PLL reset, waits for a filtered lock, then releases core reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SOFT_HOLD     = DEF_SOFT_HOLD
) (
  input wire logic               refclk,
  input wire logic               rst,
  pll_reset_sequencer_if.slave   bus
);

  localparam int CW = CNT_W(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int HW = (SOFT_HOLD < 1) ? 1 : $clog2(SOFT_HOLD + 1);

  localparam logic [CW-1:0]      RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]      TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]      STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [HW-1:0]      HOLD_N   = HW'(SOFT_HOLD);
  localparam logic [HW-1:0]      HOLD_ONE = HW'(1);
  localparam logic [RETRY_W-1:0] RETRY_MX = '1;

  logic               lock_s;
  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [HW-1:0]      hold_q;
  logic [RETRY_W-1:0] retry_q;
  logic               pll_rst_q;
  logic               core_reset_q;
  logic               ready_q;
  logic               lock_lost_q;

  sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d_i (bus.pll_locked),
    .q_o (lock_s)
  );

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      hold_q       <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          // Lock is tested before the timeout so a simultaneous lock wins.
          if (lock_s) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TMO_LAST) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            if (retry_q != RETRY_MX) retry_q <= retry_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STB_LAST) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            hold_q       <= '0;
            core_reset_q <= 1'b0;
            ready_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            hold_q       <= '0;
            pll_rst_q    <= 1'b1;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b1;
          end else if (!core_reset_q) begin
            if (bus.soft_rst_req) begin
              core_reset_q <= 1'b1;
              ready_q      <= 1'b0;
              hold_q       <= HOLD_ONE;
            end
          end else if (!bus.soft_rst_req && hold_q >= HOLD_N) begin
            // hold_q counts cycles since the request began, saturating at the minimum.
            core_reset_q <= 1'b0;
            ready_q      <= 1'b1;
            hold_q       <= '0;
          end else if (hold_q < HOLD_N) begin
            hold_q <= hold_q + HOLD_ONE;
          end
        end
        default: begin
          state_q <= PLL_RST;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.pll_rst    = pll_rst_q;
  assign bus.core_reset = core_reset_q;
  assign bus.ready      = ready_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.lock_lost  = lock_lost_q;

endmodule

`default_nettype wire
